// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: N x N output-stationary systolic C = A*B (or C += A*B) engine
// with built-in input skew, IDLE/FEED/FLUSH/DRAIN sequencing and valid/ready streaming.
module systolic_mm_engine #(
  parameter int N      = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                accumulate,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_a,
  input  logic [N*DATA_W-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*ACC_W-1:0]  out_data,
  output logic                out_last
);
  localparam int CW = $clog2(2*N);
  localparam int RW = $clog2(N);
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, clr, fire;
  logic [N-1:0][DATA_W-1:0] a_sk, b_sk;
  logic [N-1:0] a_skv, b_skv;
  logic [N-1:0][N-1:0][DATA_W-1:0] a_in, b_in;
  logic [N-1:0][N-1:0] av_in, bv_in;
  logic [N-1:0][N-1:0][2*DATA_W-1:0] prod;
  logic [N-1:0][N-2:0][DATA_W-1:0] pa_q;
  logic [N-2:0][N-1:0][DATA_W-1:0] pb_q;
  logic [N-1:0][N-2:0] pav_q;
  logic [N-2:0][N-1:0] pbv_q;
  logic [N-1:0][N-1:0][ACC_W-1:0] acc_q;
  assign fire      = in_valid && state_q == FEED;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign in_ready  = state_q == FEED;
  assign out_valid = state_q == DRAIN;
  assign out_last  = out_valid && cnt_q == CW'(N-1);
  assign out_data  = out_valid ? acc_q[cnt_q[RW-1:0]] : '0;
  // cnt_q is the beat index in FEED, the flush timer in FLUSH and the row index in DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FEED;
        cnt_d   = '0;
        clr     = !accumulate;
      end
      FEED: if (fire) begin
        state_d = cnt_q == CW'(N-1) ? FLUSH : FEED;
        cnt_d   = cnt_q == CW'(N-1) ? '0 : cnt_q + 1'b1;
      end
      FLUSH: begin
        state_d = cnt_q == CW'(2*N-2) ? DRAIN : FLUSH;
        cnt_d   = cnt_q == CW'(2*N-2) ? '0 : cnt_q + 1'b1;
      end
      DRAIN: if (out_ready) begin
        state_d = out_last ? IDLE : DRAIN;
        cnt_d   = out_last ? '0 : cnt_q + 1'b1;
        done_d  = out_last;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  // lane i of A and lane i of B each pass through i+1 registers with a valid tag
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [i:0][DATA_W-1:0] a_sr, b_sr;
    logic [i:0] av_sr, bv_sr;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        a_sr  <= '0;
        b_sr  <= '0;
        av_sr <= '0;
        bv_sr <= '0;
      end else begin
        a_sr[0]  <= in_a[i*DATA_W +: DATA_W];
        b_sr[0]  <= in_b[i*DATA_W +: DATA_W];
        av_sr[0] <= fire;
        bv_sr[0] <= fire;
        for (int s = 1; s <= i; s++) begin
          a_sr[s]  <= a_sr[s-1];
          b_sr[s]  <= b_sr[s-1];
          av_sr[s] <= av_sr[s-1];
          bv_sr[s] <= bv_sr[s-1];
        end
      end
    end
    assign a_sk[i]  = a_sr[i];
    assign b_sk[i]  = b_sr[i];
    assign a_skv[i] = av_sr[i];
    assign b_skv[i] = bv_sr[i];
  end
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_al
        assign a_in[i][j]  = a_sk[i];
        assign av_in[i][j] = a_skv[i];
      end else begin : g_ar
        assign a_in[i][j]  = pa_q[i][j-1];
        assign av_in[i][j] = pav_q[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign b_in[i][j]  = b_sk[j];
        assign bv_in[i][j] = b_skv[j];
      end else begin : g_bb
        assign b_in[i][j]  = pb_q[i-1][j];
        assign bv_in[i][j] = pbv_q[i-1][j];
      end
      assign prod[i][j] = $signed(a_in[i][j]) * $signed(b_in[i][j]);
    end
  end
  // only the tags gate accumulation, so input bubbles flow through harmlessly
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pa_q  <= '0;
      pb_q  <= '0;
      pav_q <= '0;
      pbv_q <= '0;
      acc_q <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j < N-1) begin
            pa_q[i][j]  <= a_in[i][j];
            pav_q[i][j] <= av_in[i][j];
          end
          if (i < N-1) begin
            pb_q[i][j]  <= b_in[i][j];
            pbv_q[i][j] <= bv_in[i][j];
          end
          if (clr)
            acc_q[i][j] <= '0;
          else if (av_in[i][j] && bv_in[i][j])
            acc_q[i][j] <= acc_q[i][j] + ACC_W'($signed(prod[i][j]));
        end
    end
  end
endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised N×N output-stationary systolic matrix-multiply engine with integrated input skewing, start/done sequencing and valid/ready streaming on both sides. It computes C = A·B, or C += A·B in accumulate mode, for signed fixed-point operands. It is the generalised successor to the fixed 3×3 systolic array and removes the need for host-side diagonal skewing and manual cycle counting.

## Interface
Parameters:
- N, 3, array dimension; matrices are N×N; N ≥ 2
- DATA_W, 16, signed operand width
- ACC_W, 40, signed accumulator/result width; ACC_W ≥ 2·DATA_W

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a job; sampled only in IDLE
- accumulate  in  1  sampled with start: 0 = clear C first, 1 = add onto retained C
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final output beat transfers
- in_valid  in  1  input beat valid
- in_ready  out  1  high only in FEED
- in_a  in  N·DATA_W  column k of A; element i at [i·DATA_W +: DATA_W]
- in_b  in  N·DATA_W  row k of B; element j at [j·DATA_W +: DATA_W]
- out_valid  out  1  result row valid
- out_ready  in  1  result row accepted
- out_data  out  N·ACC_W  row r of C; element j at [j·ACC_W +: ACC_W]
- out_last  out  1  high with row N-1

## Operation
- FSM states: IDLE → FEED → FLUSH → DRAIN → IDLE.
- IDLE, start=1: if accumulate=0, all N² accumulators clear to 0 on this edge. Enter FEED with beat counter k=0. start is ignored outside IDLE.
- FEED: in_ready=1. Each edge with in_valid&in_ready accepts beat k and increments k. After beat N-1 is accepted, in_ready drops and the FSM enters FLUSH.
- Skew: A lane i passes through i+1 registers; B lane j passes through j+1 registers. Each lane carries a valid tag.
- PE(i,j) forwards a right and b down each cycle. It performs acc += a·b only when both tags are valid, so gaps in in_valid insert bubbles without corrupting results.
- Arithmetic: full signed DATA_W×DATA_W product, sign-extended to ACC_W. Addition wraps modulo 2^ACC_W; no saturation.
- FLUSH: counts 2N-1 cycles, then the FSM enters DRAIN.
- DRAIN: row index r starts at 0. out_valid=1, out_data = row r of the accumulators, out_last=(r==N-1).
- On each out_valid&out_ready, r increments. The transfer at r=N-1 returns the FSM to IDLE and pulses done on the next cycle.
- out_data is held stable while out_valid&!out_ready.
- Accumulators are retained after DRAIN. They are cleared only by start with accumulate=0, or by reset.

## Timing
- Reset (async assert, sync release): state=IDLE; accumulators, skew registers and tags = 0; busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_data=0.
- Reset asserted mid-job aborts immediately. No done pulse is produced and no partial output is emitted.
- start edge → busy=1 and in_ready=1 in the next cycle.
- Update timing: beat k accepted at edge E_k updates PE(i,j) at edge E_k+i+j+1.
- Last accepted beat at edge E → final update at E+2N-1 → out_valid=1 from the cycle after E+2N-1. For N=3, out_valid rises 5 cycles after E.
- With out_ready held high, DRAIN takes N cycles. done is high for exactly one cycle, with busy=0 in that same cycle.
- Minimum job length with no stalls: 1 (start) + N + (2N-1) + N + 1 cycles.

## Test plan
- N=3, DATA_W=16, accumulate=0: A=identity, B=[[1,2,3],[4,5,6],[7,8,9]], no stalls → rows out {1,2,3},{4,5,6},{7,8,9}; out_valid rises 5 cycles after the last input edge; out_last on row 2; one done pulse.
- Signed data: A=[[-1,2,0],[3,-4,5],[0,0,-6]], B=[[2,0,-1],[1,1,1],[0,-3,4]] → C=[[0,2,3],[2,-19,13],[0,18,-24]].
- Accumulate: repeat the identity job with accumulate=1 → C={2,4,6},{8,10,12},{14,16,18}. A third job with accumulate=0 returns to {1,2,3},… .
- Backpressure: in_valid toggled 1,0,0,1,0,1 and out_ready low for 3 cycles per row → same C as the first scenario; out_data stable during stalls; in_ready=0 outside FEED.
- Wrap: DATA_W=8, ACC_W=16, all A and B elements = -128 → every C element = 49152 mod 2^16 = -16384 (0xC000).
- Reset during FEED after 2 beats, then a clean job, start asserted while busy, ignored → all outputs 0 during reset; the clean job's results are correct; the ignored start causes no extra job.
